// File: rtl/bfly_seq_ctrl.sv
// Parametrised load/compute/display sequencer for the FFT butterfly datapath.
// Optional feature macro: BFLY_AUTO_DISPLAY_EN (timed display slots instead of ReadyIn-stepped).
module bfly_seq_ctrl #(
    parameter int NUM_LOADS   = 3,
    parameter int SPLIT_AT    = 2,
    parameter int SPLIT_STEPS = 3,
    parameter int CALC_STEPS  = 6,
    parameter int NUM_OUTS    = 4,
    parameter int DISP_HOLD   = 8
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  ReadyIn,
    input  logic                  Abort,
    output logic                  clear,
    output logic [NUM_LOADS-1:0]  load_en,
    output logic [CALC_STEPS-1:0] calc_en,
    output logic [NUM_OUTS-1:0]   disp_en,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = (NUM_LOADS  > 1) ? $clog2(NUM_LOADS)  : 1;
    localparam int CW = (CALC_STEPS > 1) ? $clog2(CALC_STEPS) : 1;
    localparam int DW = (NUM_OUTS   > 1) ? $clog2(NUM_OUTS)   : 1;

    localparam logic [LW-1:0] LD_LAST  = LW'(NUM_LOADS - 1);
    localparam logic [LW-1:0] LD_SPLIT = LW'(SPLIT_AT - 1);
    localparam logic [CW-1:0] C_LAST   = CW'(CALC_STEPS - 1);
    localparam logic [CW-1:0] C_SPLIT  = CW'(SPLIT_STEPS - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(NUM_OUTS - 1);
    localparam bit            HAS_SPLIT = (SPLIT_STEPS > 0);

    typedef enum logic [2:0] {IDLE, ARMED, LOADP, CALC, DISP} state_t;

    state_t        state;
    logic [LW-1:0] ldIdx;
    logic [CW-1:0] cIdx;
    logic [DW-1:0] dIdx;
    logic          readyQ;
    logic          doneQ;
    logic          rise;
    logic          dispStep;

    assign rise = ReadyIn & ~readyQ;

`ifdef BFLY_AUTO_DISPLAY_EN
    localparam int HW = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(DISP_HOLD - 1);

    logic [HW-1:0] holdCnt;

    assign dispStep = (holdCnt == HOLD_LAST);

    // Held at zero outside DISP so every slot, including the first, lasts DISP_HOLD cycles.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            holdCnt <= '0;
        else if (Abort || state != DISP || dispStep)
            holdCnt <= '0;
        else
            holdCnt <= holdCnt + 1'b1;
    end
`else
    assign dispStep = rise;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            ldIdx  <= '0;
            cIdx   <= '0;
            dIdx   <= '0;
            readyQ <= 1'b1;
            doneQ  <= 1'b0;
        end else begin
            readyQ <= ReadyIn;
            doneQ  <= 1'b0;
            if (Abort) begin
                state <= IDLE;
                ldIdx <= '0;
                cIdx  <= '0;
                dIdx  <= '0;
            end else begin
                case (state)
                    IDLE:  if (!ReadyIn) state <= ARMED;
                    ARMED: if (rise) state <= LOADP;
                    LOADP: begin
                        // ldIdx wraps to zero after the last load; CALC uses that as "no loads left".
                        if (ldIdx == LD_LAST) begin
                            ldIdx <= '0;
                            state <= CALC;
                        end else begin
                            ldIdx <= ldIdx + 1'b1;
                            state <= (HAS_SPLIT && ldIdx == LD_SPLIT) ? CALC : ARMED;
                        end
                    end
                    CALC: begin
                        if (cIdx == C_LAST) begin
                            cIdx  <= '0;
                            dIdx  <= '0;
                            state <= DISP;
                        end else begin
                            cIdx <= cIdx + 1'b1;
                            if (HAS_SPLIT && cIdx == C_SPLIT && ldIdx != '0)
                                state <= ARMED;
                        end
                    end
                    DISP: begin
                        if (dispStep) begin
                            if (dIdx == D_LAST) begin
                                dIdx  <= '0;
                                state <= IDLE;
                                doneQ <= 1'b1;
                            end else begin
                                dIdx <= dIdx + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        clear   = (state == IDLE);
        busy    = (state != IDLE);
        done    = doneQ;
        load_en = '0;
        calc_en = '0;
        disp_en = '0;
        case (state)
            LOADP:   load_en = NUM_LOADS'(1) << ldIdx;
            CALC:    calc_en = CALC_STEPS'(1) << cIdx;
            DISP:    disp_en = NUM_OUTS'(1) << dIdx;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bfly_seq_ctrl.sv
// Scoreboard bench for bfly_seq_ctrl: default-parameter instance plus a reduced two-load instance.
module tb_bfly_seq_ctrl;

    logic       Clock;
    logic       nReset;
    logic       ReadyIn, Abort;
    logic       clear, busy, done;
    logic [2:0] load_en;
    logic [5:0] calc_en;
    logic [3:0] disp_en;

    logic       rdy2, ab2;
    logic       clear2, busy2, done2;
    logic [1:0] load2, calc2, disp2;

    typedef struct packed {
        logic       clear;
        logic [2:0] ld;
        logic [5:0] ca;
        logic [3:0] di;
        logic       busy;
        logic       done;
    } o_t;

    typedef struct packed {
        logic       clear;
        logic [1:0] ld;
        logic [1:0] ca;
        logic [1:0] di;
        logic       busy;
        logic       done;
    } s_t;

    typedef struct packed {
        logic rdy;
        logic ab;
    } st_t;

    o_t  expQ[$];
    st_t stQ[$];
    s_t  expS[$];
    st_t stS[$];

    int unsigned passCnt  = 0;
    int unsigned totalCnt = 0;

    bfly_seq_ctrl #(.DISP_HOLD(4)) dut (
        .Clock(Clock), .nReset(nReset), .ReadyIn(ReadyIn), .Abort(Abort),
        .clear(clear), .load_en(load_en), .calc_en(calc_en), .disp_en(disp_en),
        .busy(busy), .done(done)
    );

    bfly_seq_ctrl #(
        .NUM_LOADS(2), .SPLIT_AT(2), .SPLIT_STEPS(0), .CALC_STEPS(2), .NUM_OUTS(2), .DISP_HOLD(4)
    ) dutSmall (
        .Clock(Clock), .nReset(nReset), .ReadyIn(rdy2), .Abort(ab2),
        .clear(clear2), .load_en(load2), .calc_en(calc2), .disp_en(disp2),
        .busy(busy2), .done(done2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic o_t mk(logic c, logic [2:0] l, logic [5:0] ca, logic [3:0] d, logic dn);
        o_t r;
        r.clear = c; r.ld = l; r.ca = ca; r.di = d; r.busy = ~c; r.done = dn;
        return r;
    endfunction

    function automatic o_t fIdle(logic dn); return mk(1'b1, 3'd0, 6'd0, 4'd0, dn); endfunction
    function automatic o_t fArm();          return mk(1'b0, 3'd0, 6'd0, 4'd0, 1'b0); endfunction
    function automatic o_t fLd(logic [2:0] l); return mk(1'b0, l, 6'd0, 4'd0, 1'b0); endfunction
    function automatic o_t fCa(logic [5:0] c); return mk(1'b0, 3'd0, c, 4'd0, 1'b0); endfunction
    function automatic o_t fDi(logic [3:0] d); return mk(1'b0, 3'd0, 6'd0, d, 1'b0); endfunction

    function automatic s_t sk(logic c, logic [1:0] l, logic [1:0] ca, logic [1:0] d, logic dn);
        s_t r;
        r.clear = c; r.ld = l; r.ca = ca; r.di = d; r.busy = ~c; r.done = dn;
        return r;
    endfunction

    // Expected outputs at one falling edge, then the inputs to apply right after it.
    task automatic push(input logic r, input logic a, input o_t e);
        expQ.push_back(e);
        stQ.push_back('{rdy: r, ab: a});
    endtask

    task automatic pushS(input logic r, input logic a, input s_t e);
        expS.push_back(e);
        stS.push_back('{rdy: r, ab: a});
    endtask

    function automatic o_t obs();
        return {clear, load_en, calc_en, disp_en, busy, done};
    endfunction

    task automatic test_reset;
        o_t o;
        s_t so;
        nReset = 1'b0; ReadyIn = 1'b0; Abort = 1'b0; rdy2 = 1'b0; ab2 = 1'b0;
        repeat (2) @(negedge Clock);
        o = obs();
        totalCnt++;
        if (o !== fIdle(1'b0)) $display("FAIL reset_main: got %h want %h", o, fIdle(1'b0));
        else passCnt++;
        so = {clear2, load2, calc2, disp2, busy2, done2};
        totalCnt++;
        if (so !== sk(1'b1, 2'd0, 2'd0, 2'd0, 1'b0))
            $display("FAIL reset_small: got %h want %h", so, sk(1'b1, 2'd0, 2'd0, 2'd0, 1'b0));
        else passCnt++;
        nReset = 1'b1;
    endtask

    task automatic test_small_cfg;
        s_t e, so;
        st_t s;
        int n = 0;
        pushS(1, 0, sk(0, 0, 0, 0, 0));
        pushS(0, 0, sk(0, 2'b01, 0, 0, 0));
        pushS(1, 0, sk(0, 0, 0, 0, 0));
        pushS(0, 0, sk(0, 2'b10, 0, 0, 0));
        pushS(0, 0, sk(0, 0, 2'b01, 0, 0));
        pushS(0, 0, sk(0, 0, 2'b10, 0, 0));
        pushS(0, 1, sk(0, 0, 0, 2'b01, 0));
        pushS(0, 0, sk(1, 0, 0, 0, 0));
        while (expS.size() != 0) begin
            @(negedge Clock);
            e = expS.pop_front();
            s = stS.pop_front();
            so = {clear2, load2, calc2, disp2, busy2, done2};
            totalCnt++;
            if (so !== e) $display("FAIL small_cfg step %0d: got %h want %h", n, so, e);
            else passCnt++;
            rdy2 = s.rdy; ab2 = s.ab; n++;
        end
    endtask

    task automatic test_full_run;
        o_t e, o;
        st_t s;
        int n = 0;
        push(1, 0, fArm());   push(1, 0, fLd(3'b001)); push(0, 0, fArm());
        push(1, 0, fArm());   push(1, 0, fLd(3'b010));
        push(1, 0, fCa(6'b000001)); push(1, 0, fCa(6'b000010)); push(1, 0, fCa(6'b000100));
        push(0, 0, fArm());   push(1, 0, fArm());      push(1, 0, fLd(3'b100));
        push(1, 0, fCa(6'b001000)); push(1, 0, fCa(6'b010000)); push(1, 0, fCa(6'b100000));
`ifdef BFLY_AUTO_DISPLAY_EN
        // Four slots of four cycles each; ReadyIn toggles throughout and must be ignored.
        for (int k = 0; k < 16; k++) push(k[0], 0, fDi(4'(1 << (k / 4))));
        push(1, 0, fIdle(1'b1));
`else
        push(0, 0, fDi(4'b0001)); push(1, 0, fDi(4'b0001));
        push(0, 0, fDi(4'b0010)); push(1, 0, fDi(4'b0010));
        push(0, 0, fDi(4'b0100)); push(1, 0, fDi(4'b0100));
        push(0, 0, fDi(4'b1000)); push(1, 0, fDi(4'b1000));
        push(1, 0, fIdle(1'b1));
`endif
        push(0, 0, fIdle(1'b0)); push(0, 0, fArm());
        while (expQ.size() != 0) begin
            @(negedge Clock);
            e = expQ.pop_front();
            s = stQ.pop_front();
            o = obs();
            totalCnt++;
            if (o !== e) $display("FAIL full_run step %0d: got %h want %h", n, o, e);
            else passCnt++;
            ReadyIn = s.rdy; Abort = s.ab; n++;
        end
    endtask

    task automatic test_toggle_during_calc;
        o_t e, o;
        st_t s;
        int n = 0;
        push(1, 0, fArm()); push(0, 0, fLd(3'b001)); push(1, 0, fArm()); push(0, 0, fLd(3'b010));
        push(1, 0, fCa(6'b000001)); push(0, 0, fCa(6'b000010)); push(1, 0, fCa(6'b000100));
        push(1, 0, fArm()); push(1, 0, fArm()); push(0, 0, fArm()); push(1, 0, fArm());
        push(0, 0, fLd(3'b100));
        push(0, 0, fCa(6'b001000)); push(0, 0, fCa(6'b010000)); push(0, 0, fCa(6'b100000));
        push(0, 1, fDi(4'b0001)); push(0, 0, fIdle(1'b0)); push(0, 0, fArm());
        while (expQ.size() != 0) begin
            @(negedge Clock);
            e = expQ.pop_front();
            s = stQ.pop_front();
            o = obs();
            totalCnt++;
            if (o !== e) $display("FAIL toggle_calc step %0d: got %h want %h", n, o, e);
            else passCnt++;
            ReadyIn = s.rdy; Abort = s.ab; n++;
        end
    endtask

    task automatic test_abort;
        o_t e, o;
        st_t s;
        int n = 0;
        push(1, 0, fArm()); push(0, 0, fLd(3'b001)); push(1, 0, fArm()); push(0, 0, fLd(3'b010));
        push(0, 0, fCa(6'b000001)); push(0, 1, fCa(6'b000010)); push(0, 0, fIdle(1'b0));
        push(1, 0, fArm()); push(0, 0, fLd(3'b001)); push(1, 0, fArm()); push(0, 0, fLd(3'b010));
        push(0, 1, fCa(6'b000001)); push(0, 0, fIdle(1'b0)); push(0, 0, fArm());
        while (expQ.size() != 0) begin
            @(negedge Clock);
            e = expQ.pop_front();
            s = stQ.pop_front();
            o = obs();
            totalCnt++;
            if (o !== e) $display("FAIL abort step %0d: got %h want %h", n, o, e);
            else passCnt++;
            ReadyIn = s.rdy; Abort = s.ab; n++;
        end
    endtask

    task automatic test_hold_through_reset;
        o_t e, o;
        st_t s;
        int n = 0;
        @(negedge Clock);
        nReset = 1'b0; ReadyIn = 1'b1; Abort = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
        push(1, 0, fIdle(1'b0)); push(1, 0, fIdle(1'b0)); push(0, 0, fIdle(1'b0));
        push(1, 0, fArm());      push(1, 0, fLd(3'b001));
        while (expQ.size() != 0) begin
            @(negedge Clock);
            e = expQ.pop_front();
            s = stQ.pop_front();
            o = obs();
            totalCnt++;
            if (o !== e) $display("FAIL hold_reset step %0d: got %h want %h", n, o, e);
            else passCnt++;
            ReadyIn = s.rdy; Abort = s.ab; n++;
        end
        // Mid-sequence reset must take effect without waiting for a clock edge.
        nReset = 1'b0;
        #1;
        o = obs();
        totalCnt++;
        if (o !== fIdle(1'b0)) $display("FAIL async_reset: got %h want %h", o, fIdle(1'b0));
        else passCnt++;
        @(negedge Clock);
        nReset = 1'b1; ReadyIn = 1'b0;
        @(negedge Clock);
        o = obs();
        totalCnt++;
        if (o !== fArm()) $display("FAIL rearm_after_reset: got %h want %h", o, fArm());
        else passCnt++;
    endtask

    initial begin
        test_reset;
        test_small_cfg;
        test_full_run;
        test_toggle_during_calc;
        test_abort;
        test_hold_through_reset;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/bfly_seq_ctrl.md
# bfly_seq_ctrl

Parametrised sequencer for the FFT butterfly datapath. It generalises the fixed W/B/A load, compute and display flow to configurable operand-load, compute-step and display-output counts, all driven by the debounced ReadyIn switch. Loads and displays advance on detected ReadyIn rising edges. Outputs are one-hot strobe vectors that the butterfly datapath decodes directly; the block also adds a synchronous abort and a done pulse.

## Interface
- NUM_LOADS, 3: number of operand loads (W, B, A by default).
- SPLIT_AT, 2: the first SPLIT_STEPS compute steps run after this many loads; range 1..NUM_LOADS.
- SPLIT_STEPS, 3: number of compute steps in the mid-sequence group; range 0..CALC_STEPS.
- CALC_STEPS, 6: total compute steps. Steps SPLIT_STEPS..CALC_STEPS-1 run after the last load.
- NUM_OUTS, 4: number of display results (ReY, ImY, ReZ, ImZ by default).
- DISP_HOLD, 8: cycles per display slot. Used only with auto-display; must be ≥ 1.
- Clock  in  1  clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- ReadyIn  in  1  debounced switch level.
- Abort  in  1  synchronous, active-high return to IDLE.
- clear  out  1  high while in IDLE.
- load_en  out  NUM_LOADS  one-hot, one-cycle load strobe.
- calc_en  out  CALC_STEPS  one-hot, one-cycle compute strobe.
- disp_en  out  NUM_OUTS  one-hot display select (level).
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on completion of the display sequence.

## Operation
- Edge detect: ready_q <= ReadyIn each cycle; ready_q resets to 1. rise = ReadyIn & ~ready_q. A level held high through reset is therefore not a rise.
- States and transitions:
  - IDLE -> ARMED when ReadyIn == 0.
  - ARMED -> LOADP on rise.
  - LOADP (strobes load_en[ld_idx]) -> CALC if the split group is due, CALC if this is the last load, else ARMED. ld_idx increments.
  - CALC (strobes calc_en[c_idx], c_idx increments) -> next state determined by the rules below.
  - DISP (disp_en[d_idx]) -> advances on rise; a rise at the last d_idx -> IDLE.
- CALC exit rules:
  - At the end of the split group (c_idx == SPLIT_STEPS-1) with loads remaining -> ARMED.
  - At c_idx == CALC_STEPS-1 -> DISP, with d_idx = 0.
- SPLIT_STEPS == 0: no mid group; LOADP after load SPLIT_AT-1 goes to ARMED.
- SPLIT_AT == NUM_LOADS: both groups run back-to-back after the last load.
- Rises during LOADP or CALC are ignored, not queued. ready_q keeps tracking during these states.
- Abort has the highest priority:
  - Next state is IDLE from any state.
  - All strobes are deasserted from the following cycle.
  - ld_idx, c_idx and d_idx clear.
  - done is not asserted.
- done pulses for the first IDLE cycle after normal DISP exit only.
- Counter widths are $clog2 of the respective parameter, with a minimum of 1.
- Only one of load_en, calc_en and disp_en is non-zero in any cycle.

## Timing
- Reset values:
  - State IDLE; clear = 1.
  - load_en = 0, calc_en = 0, disp_en = 0.
  - busy = 0, done = 0.
  - All indices = 0.
- Outputs are Moore, decoded from registered state and indices.
- load_en[k] is high for exactly the cycle after the edge at which the rise is sampled.
- calc_en steps occupy consecutive cycles with no gaps. The first step occupies the cycle after LOADP.
- disp_en[0] goes high the cycle after the last calc step.
- A rise in DISP changes disp_en on the following cycle.
- Reset asserted mid-sequence: immediate asynchronous return to reset values.

## Configuration
- BFLY_AUTO_DISPLAY_EN defined:
  - DISP advances on a hold counter. Each disp_en slot is held for exactly DISP_HOLD cycles.
  - After the last slot the block enters IDLE with done.
  - Rises in DISP are ignored; Abort still applies.
- BFLY_AUTO_DISPLAY_EN undefined: DISP advances only on rise, as described above; no hold counter is built.

## Test plan
- Default parameters, full run:
  - Reset, then ReadyIn 0 -> 1 (t1): load_en = 001.
  - Next rise: load_en = 010, then calc_en = 000001, 000010, 000100 on the next 3 cycles.
  - Next rise: load_en = 100, then calc_en = 001000, 010000, 100000.
  - Then disp_en = 0001. Three rises -> 0010, 0100, 1000. Fourth rise -> clear = 1 and done = 1 for one cycle.
- ReadyIn held at 1 through reset release: no load_en until ReadyIn goes 0 then 1. First strobe load_en = 001.
- ReadyIn toggling during the calc_en burst (default parameters): burst is uninterrupted. The block waits in ARMED for a fresh rise before load_en = 100.
- Abort asserted during calc_en = 000010: next cycle calc_en = 0 and clear = 1. done stays 0. The next run restarts at load_en = 001.
- NUM_LOADS = 2, SPLIT_AT = 2, SPLIT_STEPS = 0, CALC_STEPS = 2, NUM_OUTS = 2:
  - Two rises -> load_en = 01, then 10.
  - Then calc_en = 01, 10, then disp_en = 01.
- BFLY_AUTO_DISPLAY_EN defined, DISP_HOLD = 4, defaults otherwise:
  - Each disp_en value is held for exactly 4 cycles; rises have no effect.
  - done pulses 16 cycles after disp_en = 0001 first appears.
